// File: rtl/dsconv1_stream_ctrl_if.sv
// Control-plane bundle between the conv-stage sequencer and its surroundings:
// weight byte stream, register-file writes, pixel stream and window output.
interface dsconv1_stream_ctrl_if;
    logic       start;
    logic       reload;
    logic       wt_valid;
    logic [7:0] wt_data;
    logic       wt_ready;
    logic       wt_we;
    logic [4:0] wt_addr;
    logic [7:0] wt_wdata;
    logic       pix_valid;
    logic       pix_ready;
    logic       shift_en;
    logic       win_valid;
    logic       out_ready;
    logic [4:0] out_row;
    logic [4:0] out_col;
    logic       wts_loaded;
    logic       busy;
    logic       frame_done;

    modport master (
        output start, reload, wt_valid, wt_data, pix_valid, out_ready,
        input  wt_ready, wt_we, wt_addr, wt_wdata, pix_ready, shift_en,
               win_valid, out_row, out_col, wts_loaded, busy, frame_done
    );

    modport slave (
        input  start, reload, wt_valid, wt_data, pix_valid, out_ready,
        output wt_ready, wt_we, wt_addr, wt_wdata, pix_ready, shift_en,
               win_valid, out_row, out_col, wts_loaded, busy, frame_done
    );
endinterface

// File: rtl/dsconv1_stream_ctrl.sv
// Sequencer for the first depthwise-separable conv stage: weight load,
// raster pixel intake, interior-window tagging and frame completion.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD_W | streaming N_WT weight/bias bytes into the datapath reg file
// RUN    | accepting pixels, emitting windows
// DRAIN  | last pixel taken, waiting for the final window to be consumed
module dsconv1_stream_ctrl #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int K     = 5,
    parameter int N_WT  = 31
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dsconv1_stream_ctrl_if.slave  bus
);
    localparam logic [4:0] KM1      = 5'(K - 1);
    localparam logic [4:0] LAST_COL = 5'(IMG_W - 1);
    localparam logic [4:0] LAST_ROW = 5'(IMG_H - 1);
    localparam logic [4:0] LAST_WT  = 5'(N_WT - 1);

    typedef enum logic [1:0] {IDLE, LOAD_W, RUN, DRAIN} state_t;

    state_t     state, state_nxt;
    logic [4:0] row, col, wt_cnt;
    logic       wts_loaded, win_valid, frame_done, wt_we;
    logic [4:0] wt_addr, out_row, out_col;
    logic [7:0] wt_wdata;
    logic       wt_ready, pix_ready;
    logic       wt_hs, pix_hs, last_pix, interior, need_load;

    assign wt_hs     = bus.wt_valid && wt_ready;
    assign pix_hs    = bus.pix_valid && pix_ready;
    assign last_pix  = (row == LAST_ROW) && (col == LAST_COL);
    assign interior  = (row >= KM1) && (col >= KM1);
    assign need_load = bus.reload || !wts_loaded;

    always_comb begin
        state_nxt = state;
        wt_ready  = 1'b0;
        pix_ready = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start)
                    state_nxt = need_load ? LOAD_W : RUN;
            end
            LOAD_W: begin
                wt_ready = 1'b1;
                if (bus.wt_valid && wt_cnt == LAST_WT)
                    state_nxt = RUN;
            end
            RUN: begin
                // a stalled window blocks intake so the line buffer stays aligned
                pix_ready = !(win_valid && !bus.out_ready);
                if (bus.pix_valid && pix_ready && last_pix)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!win_valid || bus.out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            row        <= '0;
            col        <= '0;
            wt_cnt     <= '0;
            wts_loaded <= 1'b0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            wt_we      <= 1'b0;
            wt_addr    <= '0;
            wt_wdata   <= '0;
            out_row    <= '0;
            out_col    <= '0;
        end else begin
            state      <= state_nxt;
            wt_we      <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        row    <= '0;
                        col    <= '0;
                        wt_cnt <= '0;
                        if (need_load)
                            wts_loaded <= 1'b0;
                    end
                end
                LOAD_W: begin
                    if (wt_hs) begin
                        wt_we    <= 1'b1;
                        wt_addr  <= wt_cnt;
                        wt_wdata <= bus.wt_data;
                        if (wt_cnt == LAST_WT) begin
                            wt_cnt     <= '0;
                            wts_loaded <= 1'b1;
                        end else begin
                            wt_cnt <= wt_cnt + 5'd1;
                        end
                    end
                end
                RUN: begin
                    if (pix_hs) begin
                        if (last_pix) begin
                            row <= '0;
                            col <= '0;
                        end else if (col == LAST_COL) begin
                            col <= '0;
                            row <= row + 5'd1;
                        end else begin
                            col <= col + 5'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (!win_valid || bus.out_ready)
                        frame_done <= 1'b1;
                end
                default: ;
            endcase

            // window register: a new interior pixel replaces a consumed window in place
            if (pix_hs && interior) begin
                win_valid <= 1'b1;
                out_row   <= row - KM1;
                out_col   <= col - KM1;
            end else if (bus.out_ready) begin
                win_valid <= 1'b0;
            end
        end
    end

    assign bus.wt_ready   = wt_ready;
    assign bus.pix_ready  = pix_ready;
    assign bus.shift_en   = pix_hs;
    assign bus.wt_we      = wt_we;
    assign bus.wt_addr    = wt_addr;
    assign bus.wt_wdata   = wt_wdata;
    assign bus.win_valid  = win_valid;
    assign bus.out_row    = out_row;
    assign bus.out_col    = out_col;
    assign bus.wts_loaded = wts_loaded;
    assign bus.busy       = (state != IDLE);
    assign bus.frame_done = frame_done;
endmodule

// File: tb/tb_dsconv1_stream_ctrl.sv
// Randomized bench for dsconv1_stream_ctrl against a frame-level reference:
// expected window list from pixel raster index, expected reg-file writes per load.
module tb_dsconv1_stream_ctrl;
    localparam int IMG_W = 28;
    localparam int IMG_H = 28;
    localparam int K     = 5;
    localparam int N_WT  = 31;
    localparam int N_WIN = (IMG_W - K + 1) * (IMG_H - K + 1);
    localparam int N_PIX = IMG_W * IMG_H;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dsconv1_stream_ctrl_if bus();
    dsconv1_stream_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .N_WT(N_WT))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int total = 0;
    int bad   = 0;

    // reference-model state
    int         pix_idx, w_idx;
    int         win_cnt = 0, fd_cnt = 0, wt_hs_cnt = 0, pix_tot = 0;
    bit         w_pend, lat_pend, stall_prev, loaded_model;
    int         w_pa, w_pd, lat_exp, stall_coord;
    int         exp_q[$];

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int coord();
        return int'({bus.out_row, bus.out_col});
    endfunction

    task automatic monitor();
        int r, c;
        chk("wt_we", int'(bus.wt_we), int'(w_pend));
        if (w_pend && bus.wt_we) begin
            chk("wt_addr", int'(bus.wt_addr), w_pa);
            chk("wt_wdata", int'(bus.wt_wdata), w_pd);
        end
        if (lat_pend) begin
            chk("win_lat", int'(bus.win_valid), 1);
            chk("win_coord", coord(), lat_exp);
        end else if (stall_prev) begin
            chk("hold_valid", int'(bus.win_valid), 1);
            chk("hold_coord", coord(), stall_coord);
        end
        if (bus.win_valid && bus.out_ready) begin
            if (exp_q.size() == 0) chk("win_spurious", 1, 0);
            else chk("win_out", coord(), exp_q.pop_front());
            win_cnt++;
        end
        if (bus.win_valid && !bus.out_ready) chk("stall_pix_ready", int'(bus.pix_ready), 0);
        stall_prev  = bus.win_valid && !bus.out_ready;
        stall_coord = coord();
        lat_pend    = 1'b0;

        if (bus.start && !bus.busy) begin
            pix_idx = 0;
            w_idx   = 0;
        end
        w_pend = bus.wt_valid && bus.wt_ready;
        if (w_pend) begin
            w_pa = w_idx;
            w_pd = int'(bus.wt_data);
            w_idx++;
            wt_hs_cnt++;
        end
        chk("shift_en", int'(bus.shift_en), int'(bus.pix_valid && bus.pix_ready));
        if (bus.pix_valid && bus.pix_ready) begin
            r = pix_idx / IMG_W;
            c = pix_idx % IMG_W;
            if (r >= K - 1 && c >= K - 1) begin
                lat_exp  = (r - (K - 1)) * 32 + (c - (K - 1));
                lat_pend = 1'b1;
                exp_q.push_back(lat_exp);
            end
            pix_idx++;
            pix_tot++;
        end
        if (bus.frame_done) fd_cnt++;
    endtask

    task automatic tick();
        @(negedge clk);
        if (rst_n) monitor();
        else begin
            w_pend = 0; lat_pend = 0; stall_prev = 0;
            pix_idx = 0; w_idx = 0;
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values();
        chk("rst_win_valid", int'(bus.win_valid), 0);
        chk("rst_frame_done", int'(bus.frame_done), 0);
        chk("rst_wt_we", int'(bus.wt_we), 0);
        chk("rst_wt_addr", int'(bus.wt_addr), 0);
        chk("rst_wt_wdata", int'(bus.wt_wdata), 0);
        chk("rst_out_row", int'(bus.out_row), 0);
        chk("rst_out_col", int'(bus.out_col), 0);
        chk("rst_wts_loaded", int'(bus.wts_loaded), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_wt_ready", int'(bus.wt_ready), 0);
        chk("rst_pix_ready", int'(bus.pix_ready), 0);
    endtask

    task automatic run_frame(input bit rl, input bit seq_data, input int gap, input int stall_pct,
                             input bit stray, input bit abort, input bit hold57);
        int w0, win0, fd0, p0, cyc, hold;
        bit exp_load, held, mid_chk, aborted;
        w0 = wt_hs_cnt; win0 = win_cnt; fd0 = fd_cnt; p0 = pix_tot;
        exp_load = rl || !loaded_model;
        cyc = 0; hold = 0; held = 0; mid_chk = 0; aborted = 0;
        bus.start  = 1'b1;
        bus.reload = rl;
        tick();
        bus.start  = 1'b0;
        bus.reload = 1'($urandom_range(1));
        while (fd_cnt == fd0 && cyc < 20000) begin
            bus.wt_valid  = ($urandom_range(99) >= gap);
            bus.wt_data   = seq_data ? 8'(w_idx) : 8'($urandom_range(255));
            bus.pix_valid = ($urandom_range(99) >= gap);
            if (hold57 && !held && bus.win_valid && bus.out_row == 5'd5 && bus.out_col == 5'd7) begin
                hold = 3;
                held = 1'b1;
            end
            if (hold > 0) begin
                bus.out_ready = 1'b0;
                hold--;
            end else begin
                bus.out_ready = ($urandom_range(99) >= stall_pct);
            end
            bus.start = stray && bus.busy && ($urandom_range(99) < 5);
            if (exp_load && !mid_chk && wt_hs_cnt - w0 == 15) begin
                chk("wts_loaded_mid", int'(bus.wts_loaded), 0);
                mid_chk = 1'b1;
            end
            if (abort && pix_tot - p0 == 10 * IMG_W + 3) begin
                aborted = 1'b1;
                break;
            end
            tick();
            cyc++;
        end
        bus.start = 1'b0;
        if (abort) begin
            chk("abort_reached", int'(aborted), 1);
            rst_n = 1'b0;
            tick();
            check_reset_values();
            rst_n = 1'b1;
            loaded_model = 1'b0;
            bus.pix_valid = 1'b0;
            bus.wt_valid  = 1'b0;
            tick();
        end else begin
            chk("frame_timeout", int'(cyc < 20000), 1);
            chk("wt_bytes", wt_hs_cnt - w0, exp_load ? N_WT : 0);
            chk("windows", win_cnt - win0, N_WIN);
            chk("pixels", pix_tot - p0, N_PIX);
            bus.pix_valid = 1'b0;
            bus.wt_valid  = 1'b0;
            bus.out_ready = 1'b1;
            repeat (3) tick();
            chk("frame_done_once", fd_cnt - fd0, 1);
            chk("idle_after", int'(bus.busy), 0);
            chk("q_empty", exp_q.size(), 0);
            chk("wts_loaded_end", int'(bus.wts_loaded), 1);
            if (hold57) chk("hold_seen", int'(held), 1);
            loaded_model = 1'b1;
        end
    endtask

    initial begin
        bus.start = 0; bus.reload = 0; bus.wt_valid = 0; bus.wt_data = 0;
        bus.pix_valid = 0; bus.out_ready = 1;
        w_pend = 0; lat_pend = 0; stall_prev = 0; loaded_model = 0;
        pix_idx = 0; w_idx = 0;
        rst_n = 1'b0;
        repeat (3) tick();
        check_reset_values();
        rst_n = 1'b1;
        tick();

        run_frame(1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);   // first start loads weights 0..30
        run_frame(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);   // no reload, stall at (5,7)
        run_frame(1'b1, 1'b0, 30, 20, 1'b1, 1'b0, 1'b0); // forced reload, gaps, stray starts
        run_frame(1'b0, 1'b0, 20, 10, 1'b0, 1'b1, 1'b0); // reset mid-frame at (10,3)
        run_frame(1'b0, 1'b0, 25, 25, 1'b1, 1'b0, 1'b1); // weights lost by reset: reload

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dsconv1_stream_ctrl.md
Name: dsconv1_stream_ctrl

Overview:
- Sequencer for the first depthwise-separable conv stage of the MNIST CNN.
- Loads the 31-byte weight/bias set (25 depthwise, 3 pointwise, 3 bias) into the conv datapath's register file over a byte stream.
- Accepts the raster pixel stream and drives the 5x5 window line buffer shift enable.
- Asserts the datapath's window-valid only for fully-interior windows, tags each output with (row, col), and handles downstream backpressure and frame completion.

Parameters:
- IMG_W, 28, image width in pixels
- IMG_H, 28, image height in pixels
- K, 5, kernel size; output map is (IMG_H-K+1) x (IMG_W-K+1)
- N_WT, 31, weight/bias bytes per load

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  pulse; begin a frame (sampled in IDLE only)
- reload  in  1  sampled with start; 1 forces a weight load before RUN
- wt_valid  in  1  weight byte valid
- wt_data  in  8  weight byte, order addr 0..N_WT-1
- wt_ready  out  1  weight byte accepted when wt_valid&&wt_ready
- wt_we  out  1  register-file write strobe to datapath
- wt_addr  out  5  register-file address
- wt_wdata  out  8  register-file write data
- pix_valid  in  1  pixel valid (raster order)
- pix_ready  out  1  pixel accepted when pix_valid&&pix_ready
- shift_en  out  1  line-buffer shift, equals pixel handshake (combinational)
- win_valid  out  1  window valid to conv datapath
- out_ready  in  1  downstream accepts window when win_valid&&out_ready
- out_row  out  5  output row of current window
- out_col  out  5  output column of current window
- wts_loaded  out  1  full weight set present
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse at frame end

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE; wts_loaded=0, win_valid=0, frame_done=0, wt_we=0, wt_addr=0, wt_wdata=0, out_row=0, out_col=0; internal row/col/weight counters=0. Reset mid-load or mid-frame aborts; wts_loaded clears.
- States: IDLE, LOAD_W, RUN, DRAIN.
- IDLE: wt_ready=0, pix_ready=0. On start: goto LOAD_W if reload||!wts_loaded, else RUN. Row/col counters cleared on start.
- LOAD_W: wt_ready=1. Each handshake registers wt_we=1, wt_addr=count, wt_wdata=wt_data next cycle (1-cycle latency); count++. wts_loaded cleared on LOAD_W entry. On byte N_WT-1 accepted: wts_loaded=1, goto RUN, count=0. wt_valid gaps stall the count; no timeout.
- RUN: pix_ready = !(win_valid && !out_ready). On handshake at pixel (r,c): shift_en=1; col++ wrapping at IMG_W-1 to 0 with row++.
  - If r>=K-1 and c>=K-1: next cycle win_valid=1, out_row=r-(K-1), out_col=c-(K-1) (1-cycle latency, aligned with line-buffer output).
  - Otherwise the pixel only fills the buffer.
  - win_valid clears on out_ready unless a new qualifying pixel is accepted in the same cycle; the new window then replaces it seamlessly.
  - win_valid, out_row and out_col are held stable while stalled.
  - Pixel (IMG_H-1, IMG_W-1) accepted: goto DRAIN.
- DRAIN: pix_ready=0. When win_valid&&out_ready (or win_valid=0): frame_done=1 for one cycle, goto IDLE; the row/col counters stay cleared until the next start.
- start in non-IDLE states and wt_valid outside LOAD_W are ignored. pix_valid outside RUN is not accepted.
- Throughput: one window per cycle with out_ready held 1; 576 windows per 28x28 frame.
- Counters are sized for IMG_W/IMG_H <= 32. Arithmetic is unsigned; no saturation is needed.

Test Plan:
- Reset then start with reload=0, wts_loaded=0 -> LOAD_W entered. Feed bytes 0x00..0x1E -> wt_we pulses 31 times at addr 0..30 with wdata=addr, one cycle after each handshake. wts_loaded=1, state RUN.
- Full 28x28 frame, pix_valid and out_ready held 1 -> first win_valid one cycle after pixel (4,4) with out_row=0, out_col=0. Exactly 576 win_valid cycles; last at (23,23). frame_done pulses once, then IDLE.
- Drop out_ready for 3 cycles while win_valid=1 at (5,7) -> pix_ready=0, win_valid/out_row/out_col stay (5,7) for 3 cycles. No pixel lost; the next window is (5,8).
- Second start with reload=0 after a frame -> LOAD_W skipped, RUN directly. With reload=1 -> full 31-byte reload, and wts_loaded=0 until the last byte.
- rst_n=0 at pixel (10,3) mid-frame -> next cycle all outputs at reset values, state IDLE. A following start performs the weight load again.
- Random pix_valid gaps plus start pulses issued during RUN -> window count is still 576 with correct coordinates; the stray starts have no effect.
